line_pixel_writer: RTL and testbench
====================================

# line_pixel_writer

Downstream consumer of the line stepper in the SimpleGPU draw pipeline. On `start`, it repeatedly samples the stepper's current pixel coordinate and clips it against the screen. In-bounds pixels become a 32-bit framebuffer address, written with a req/ack memory handshake. The block then pulses `get_pixel` to advance the stepper, until the stepper reports the line is finished.

## Interface
Parameters:
- SCREEN_WIDTH, 640, pixels per row; address stride in pixels
- SCREEN_HEIGHT, 480, number of rows
- MAX_PIXELS, 4096, runaway guard: maximum pixels processed per line

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; all state and outputs cleared
- start  in  1  one-cycle pulse; accepted only in IDLE
- fb_base  in  32  framebuffer base byte address, latched on accepted start
- color  in  32  pixel data, latched on accepted start
- abort  in  1  request early termination
- pix_x  in  16  stepper current x (unsigned)
- pix_y  in  16  stepper current y (unsigned)
- line_done  in  1  level; high = no valid pixel remains
- get_pixel  out  1  one-cycle pulse advancing the stepper
- wr_req  out  1  memory write request
- wr_addr  out  32  write byte address
- wr_data  out  32  write data
- wr_ack  in  1  memory accepts the write in the cycle it is high with wr_req
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky until next accepted start; MAX_PIXELS hit
- pixels_written  out  16  in-bounds writes this line, saturating at 0xFFFF
- pixels_clipped  out  16  out-of-bounds pixels skipped, saturating at 0xFFFF

## Operation
- States:
  - IDLE: start → SAMPLE; latch fb_base and color; clear both counters, error and the internal pixel count.
  - SAMPLE:
    - abort or line_done → DONE.
    - Internal count == MAX_PIXELS → error=1, go to DONE.
    - Else capture pix_x, pix_y and increment the internal count.
    - If pix_x ≥ SCREEN_WIDTH or pix_y ≥ SCREEN_HEIGHT: increment pixels_clipped, go to ADVANCE.
    - Else drive wr_addr = fb_base + ((pix_y*SCREEN_WIDTH + pix_x) << 2), truncated to 32 bits (wraps); wr_data = color; go to WRITE.
  - WRITE:
    - wr_req=1 with wr_addr and wr_data held stable.
    - On wr_ack: drop wr_req next cycle, increment pixels_written, go to ADVANCE.
    - abort is ignored here; it is remembered and honoured at the next SAMPLE.
  - ADVANCE: get_pixel=1 for exactly this cycle, then SETTLE.
  - SETTLE: one idle cycle so stepper outputs update, then SAMPLE.
  - DONE: done=1 for one cycle, then IDLE.
- A latched abort takes priority over line_done and the MAX_PIXELS check in SAMPLE. It is cleared on the next accepted start.
- Address arithmetic: full product y*SCREEN_WIDTH computed at ≥32 bits; no signed interpretation of pix_x/pix_y.
- start outside IDLE is ignored, including in DONE.
- wr_ack while wr_req=0 is ignored.

## Timing
- Reset values: get_pixel, wr_req, busy, done, error = 0; wr_addr, wr_data, pixels_written, pixels_clipped = 0; state IDLE.
- start at cycle 0 → busy=1 at cycle 1; SAMPLE evaluated at cycle 1.
- In-bounds pixel with wr_ack in the first wr_req cycle: 4 cycles per pixel (SAMPLE, WRITE, ADVANCE, SETTLE).
- Each wait cycle of wr_ack adds 1 cycle.
- Clipped pixel: 3 cycles (SAMPLE, ADVANCE, SETTLE); wr_req never asserted.
- done rises the cycle after the terminating SAMPLE; busy falls the cycle after done.
- Reset mid-transaction drops wr_req immediately (asynchronous); no completion pulse.
- Counters update in the cycle the event is registered and are held after DONE until the next accepted start.

## Test plan
- Horizontal line (0,0)→(3,0), fb_base=0x1000, color=0xFF00FF00, wr_ack tied 1:
  - Writes to 0x1000, 0x1004, 0x1008, 0x100C.
  - pixels_written=4; 4 get_pixel pulses; done 17 cycles after start.
- Vertical line x=2, y=0..2, SCREEN_WIDTH=640: addresses 0x0008, 0x0A08, 0x1408.
- Clipping, pix_x sequence 638, 639, 640, 641 at y=0: 2 writes, pixels_clipped=2; no wr_req for x≥640.
- Backpressure: wr_ack delayed 3 cycles on the first pixel → wr_req held 4 cycles with constant wr_addr/wr_data; no get_pixel until after ack.
- abort during WRITE: current write completes on ack, then ADVANCE, SETTLE, then DONE at the next SAMPLE; no further writes.
- line_done never asserted, MAX_PIXELS=8:
  - Exactly 8 pixels processed, error=1, done pulses.
  - Next start clears error.
  - Reset asserted mid-line returns all outputs to 0 in the same cycle.

Source files
------------

// File: rtl/line_pixel_writer.sv
// line_pixel_writer
// Consumes pixel coordinates from a line stepper, clips them against the
// screen and writes in-bounds pixels to the framebuffer over a req/ack port.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   start               one-cycle pulse, accepted only while idle
//   fb_base, color      framebuffer base byte address and pixel data (latched on start)
//   abort               early termination request (honoured at the next sample)
//   pix_x, pix_y        stepper current coordinate (unsigned)
//   line_done           stepper has no valid pixel left
//   get_pixel           one-cycle pulse advancing the stepper
//   wr_req/wr_addr/wr_data/wr_ack   memory write handshake
//   busy, done, error   status; error is sticky until the next accepted start
//   pixels_written      in-bounds writes this line (saturating)
//   pixels_clipped      out-of-bounds pixels skipped (saturating)
//
// state   | meaning
// IDLE    | waiting for start
// SAMPLE  | decide terminate / clip / write for the current stepper pixel
// WRITE   | wr_req held until wr_ack
// ADVANCE | get_pixel pulse
// SETTLE  | one cycle for the stepper outputs to update
// DONE    | one-cycle done pulse
module line_pixel_writer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int MAX_PIXELS    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] fb_base,
  input  logic [31:0] color,
  input  logic        abort,
  input  logic [15:0] pix_x,
  input  logic [15:0] pix_y,
  input  logic        line_done,
  output logic        get_pixel,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] pixels_written,
  output logic [15:0] pixels_clipped
);

  typedef enum logic [2:0] {
    IDLE, SAMPLE, WRITE, ADVANCE, SETTLE, DONE
  } state_t;

  state_t      state;
  logic [31:0] base_q;
  logic [31:0] color_q;
  logic [31:0] pix_cnt;
  logic        abort_q;

  logic [31:0] x32;
  logic [31:0] y32;
  logic [31:0] lin_idx;
  logic [31:0] addr_next;
  logic        out_of_bounds;

  // Coordinates are zero-extended before the multiply so the row offset
  // never loses bits or picks up a sign; the final address wraps at 32 bits.
  assign x32           = {16'b0, pix_x};
  assign y32           = {16'b0, pix_y};
  assign lin_idx       = y32 * 32'(SCREEN_WIDTH) + x32;
  assign addr_next     = base_q + (lin_idx << 2);
  assign out_of_bounds = (x32 >= 32'(SCREEN_WIDTH)) || (y32 >= 32'(SCREEN_HEIGHT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      base_q         <= '0;
      color_q        <= '0;
      pix_cnt        <= '0;
      abort_q        <= 1'b0;
      get_pixel      <= 1'b0;
      wr_req         <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      pixels_written <= '0;
      pixels_clipped <= '0;
    end else begin
      get_pixel <= 1'b0;
      done      <= 1'b0;
      // abort seen while a write is in flight is remembered for the next sample
      if (state != IDLE && abort) abort_q <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            base_q         <= fb_base;
            color_q        <= color;
            pix_cnt        <= '0;
            abort_q        <= 1'b0;
            error          <= 1'b0;
            pixels_written <= '0;
            pixels_clipped <= '0;
            busy           <= 1'b1;
            state          <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (abort || abort_q || line_done) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (pix_cnt == 32'(MAX_PIXELS)) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pix_cnt <= pix_cnt + 32'd1;
            if (out_of_bounds) begin
              if (pixels_clipped != 16'hFFFF) pixels_clipped <= pixels_clipped + 16'd1;
              get_pixel <= 1'b1;
              state     <= ADVANCE;
            end else begin
              wr_addr <= addr_next;
              wr_data <= color_q;
              wr_req  <= 1'b1;
              state   <= WRITE;
            end
          end
        end

        WRITE: begin
          if (wr_ack) begin
            wr_req    <= 1'b0;
            if (pixels_written != 16'hFFFF) pixels_written <= pixels_written + 16'd1;
            get_pixel <= 1'b1;
            state     <= ADVANCE;
          end
        end

        ADVANCE: state <= SETTLE;

        SETTLE: state <= SAMPLE;

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_pixel_writer.sv
module tb_line_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] fb_base;
  logic [31:0] color;
  logic        abort;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        line_done;
  logic        get_pixel;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] pixels_written;
  logic [15:0] pixels_clipped;

  int n_assert = 0;
  int n_fail   = 0;

  // stepper model
  int idx, len, x0, y0, dx, dy;
  assign pix_x     = 16'(x0 + idx * dx);
  assign pix_y     = 16'(y0 + idx * dy);
  assign line_done = (idx >= len);

  // monitor / memory responder state
  int          first_delay;
  bit          abort_arm;
  int          req_run, req_cycles, max_run, gp, nw;
  bit          unstable, gp_during_req;
  logic [31:0] held_addr, held_data;
  logic [31:0] waddr [16];
  logic [31:0] wdata [16];

  line_pixel_writer #(
    .SCREEN_WIDTH (640),
    .SCREEN_HEIGHT(480),
    .MAX_PIXELS   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .fb_base       (fb_base),
    .color         (color),
    .abort         (abort),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .line_done     (line_done),
    .get_pixel     (get_pixel),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .pixels_written(pixels_written),
    .pixels_clipped(pixels_clipped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (get_pixel) idx <= idx + 1;

  always @(negedge clk) begin
    if (abort_arm && wr_req) begin abort = 1'b1; abort_arm = 1'b0; end
    else abort = 1'b0;
    if (wr_req) begin
      if (req_run == 0) begin held_addr = wr_addr; held_data = wr_data; end
      else if (wr_addr !== held_addr || wr_data !== held_data) unstable = 1'b1;
      wr_ack = (req_run >= ((idx == 0) ? first_delay : 0));
      req_run++;
      req_cycles++;
      if (req_run > max_run) max_run = req_run;
      if (wr_ack && nw < 16) begin waddr[nw] = wr_addr; wdata[nw] = wr_data; nw++; end
    end else begin
      wr_ack  = 1'b0;
      req_run = 0;
    end
    if (get_pixel) begin gp++; if (wr_req) gp_during_req = 1'b1; end
  end

  task automatic setup_line(input int ax0, input int ay0, input int adx, input int ady,
                            input int alen, input logic [31:0] base, input logic [31:0] col);
    idx = 0; x0 = ax0; y0 = ay0; dx = adx; dy = ady; len = alen;
    fb_base = base; color = col;
    req_cycles = 0; max_run = 0; gp = 0; nw = 0; unstable = 0; gp_during_req = 0;
  endtask

  // Pulses start and returns the number of edges from the accepting edge until
  // done is seen high, or -1 if done never arrives within the budget.
  task automatic run_line(output int n);
    bit seen;
    seen = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1;
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; abort = 0; wr_ack = 0; fb_base = 0; color = 0;
    first_delay = 0; abort_arm = 0;
    setup_line(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    n_assert++;
    if ({get_pixel, wr_req, busy, done, error} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000", {get_pixel, wr_req, busy, done, error});
    end
    n_assert++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h0 || pixels_written !== 16'h0 || pixels_clipped !== 16'h0) begin
      n_fail++; $display("FAIL reset_values got addr=%h data=%h wr=%0d cl=%0d want all 0",
                         wr_addr, wr_data, pixels_written, pixels_clipped);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_horizontal();
    int n;
    setup_line(0, 0, 1, 0, 4, 32'h1000, 32'hFF00FF00);
    run_line(n);
    n_assert++;
    if (n !== 17) begin n_fail++; $display("FAIL horiz_latency got %0d want 17", n); end
    n_assert++;
    if (nw !== 4) begin n_fail++; $display("FAIL horiz_nwrites got %0d want 4", nw); end
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (waddr[i] !== 32'h1000 + 32'(i * 4) || wdata[i] !== 32'hFF00FF00) begin
        n_fail++; $display("FAIL horiz_write%0d got %h/%h want %h/ff00ff00", i, waddr[i], wdata[i], 32'h1000 + 32'(i * 4));
      end
    end
    n_assert++;
    if (pixels_written !== 16'd4 || gp !== 4 || pixels_clipped !== 16'd0) begin
      n_fail++; $display("FAIL horiz_counts got wr=%0d gp=%0d cl=%0d want 4 4 0", pixels_written, gp, pixels_clipped);
    end
    @(posedge clk); #1;
    n_assert++;
    if (busy !== 1'b0 || done !== 1'b0 || pixels_written !== 16'd4) begin
      n_fail++; $display("FAIL horiz_after got busy=%b done=%b wr=%0d want 0 0 4", busy, done, pixels_written);
    end
  endtask

  task automatic test_vertical();
    int n;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h0008; exp_a[1] = 32'h0A08; exp_a[2] = 32'h1408;
    setup_line(2, 0, 0, 1, 3, 32'h0, 32'h12345678);
    run_line(n);
    n_assert++;
    if (n !== 13 || nw !== 3) begin n_fail++; $display("FAIL vert_latency got n=%0d nw=%0d want 13 3", n, nw); end
    for (int i = 0; i < 3; i++) begin
      n_assert++;
      if (waddr[i] !== exp_a[i]) begin n_fail++; $display("FAIL vert_addr%0d got %h want %h", i, waddr[i], exp_a[i]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clip();
    int n;
    setup_line(638, 0, 1, 0, 4, 32'h0, 32'hA5A5A5A5);
    run_line(n);
    n_assert++;
    if (n !== 15) begin n_fail++; $display("FAIL clip_latency got %0d want 15", n); end
    n_assert++;
    if (nw !== 2 || req_cycles !== 2 || waddr[0] !== 32'h9F8 || waddr[1] !== 32'h9FC) begin
      n_fail++; $display("FAIL clip_writes got nw=%0d req=%0d a0=%h a1=%h want 2 2 9f8 9fc", nw, req_cycles, waddr[0], waddr[1]);
    end
    n_assert++;
    if (pixels_written !== 16'd2 || pixels_clipped !== 16'd2 || gp !== 4) begin
      n_fail++; $display("FAIL clip_counts got wr=%0d cl=%0d gp=%0d want 2 2 4", pixels_written, pixels_clipped, gp);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    setup_line(1, 1, 1, 0, 1, 32'h4000, 32'hCAFEF00D);
    first_delay = 3;
    run_line(n);
    first_delay = 0;
    n_assert++;
    if (n !== 8) begin n_fail++; $display("FAIL bp_latency got %0d want 8", n); end
    n_assert++;
    if (max_run !== 4 || unstable !== 1'b0 || gp_during_req !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold got run=%0d unstable=%b gp_in_req=%b want 4 0 0", max_run, unstable, gp_during_req);
    end
    n_assert++;
    if (waddr[0] !== 32'h4A04 || wdata[0] !== 32'hCAFEF00D || gp !== 1) begin
      n_fail++; $display("FAIL bp_write got %h/%h gp=%0d want 4a04/cafef00d 1", waddr[0], wdata[0], gp);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    int n;
    setup_line(0, 0, 1, 0, 4, 32'h0, 32'h1);
    first_delay = 2;
    abort_arm   = 1'b1;
    run_line(n);
    first_delay = 0;
    n_assert++;
    if (n !== 7) begin n_fail++; $display("FAIL abort_latency got %0d want 7", n); end
    n_assert++;
    if (nw !== 1 || req_cycles !== 3 || pixels_written !== 16'd1 || gp !== 1) begin
      n_fail++; $display("FAIL abort_counts got nw=%0d req=%0d wr=%0d gp=%0d want 1 3 1 1", nw, req_cycles, pixels_written, gp);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_runaway();
    int n;
    setup_line(0, 0, 1, 0, 100, 32'h0, 32'h77);
    run_line(n);
    n_assert++;
    if (n !== 33 || error !== 1'b1) begin n_fail++; $display("FAIL runaway_end got n=%0d err=%b want 33 1", n, error); end
    n_assert++;
    if (nw !== 8 || gp !== 8 || pixels_written !== 16'd8) begin
      n_fail++; $display("FAIL runaway_count got nw=%0d gp=%0d wr=%0d want 8 8 8", nw, gp, pixels_written);
    end
    repeat (3) @(negedge clk);
    n_assert++;
    if (error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL runaway_sticky got err=%b busy=%b want 1 0", error, busy); end
    setup_line(0, 0, 1, 0, 1, 32'h0, 32'h77);
    run_line(n);
    n_assert++;
    if (error !== 1'b0 || n !== 5) begin n_fail++; $display("FAIL runaway_clear got err=%b n=%0d want 0 5", error, n); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    setup_line(0, 0, 1, 0, 2, 32'h0, 32'h5);
    run_line(n);
    start = 1'b1;            // lands while in DONE: must be ignored
    @(posedge clk); #1;
    n_assert++;
    if (busy !== 1'b0 || pixels_written !== 16'd2) begin
      n_fail++; $display("FAIL b2b_ignore got busy=%b wr=%0d want 0 2", busy, pixels_written);
    end
    start = 1'b0;
    setup_line(10, 0, 0, 0, 1, 32'h0, 32'h6);
    run_line(n);
    n_assert++;
    if (n !== 5 || pixels_written !== 16'd1 || waddr[0] !== 32'h28) begin
      n_fail++; $display("FAIL b2b_second got n=%0d wr=%0d a=%h want 5 1 28", n, pixels_written, waddr[0]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    int dones;
    seen = 0;
    setup_line(5, 0, 1, 0, 100, 32'h2000, 32'h9);
    first_delay = 5;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_req) seen = 1;
    end
    n_assert++;
    if (!seen || wr_addr !== 32'h2014) begin n_fail++; $display("FAIL rstmid_setup got req=%b addr=%h want 1 2014", seen, wr_addr); end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_assert++;
    if ({get_pixel, wr_req, busy, done, error} !== 5'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs got flags=%b addr=%h data=%h want 0", {get_pixel, wr_req, busy, done, error}, wr_addr, wr_data);
    end
    first_delay = 0;
    @(negedge clk) reset = 1'b0;
    dones = 0;
    repeat (5) begin @(posedge clk); #1; if (done) dones++; end
    n_assert++;
    if (dones !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got dones=%0d busy=%b want 0 0", dones, busy); end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_clip();
    test_backpressure();
    test_abort();
    test_runaway();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
